// File: rtl/ror_seq_32.sv
`default_nettype none
// ============================================================================
// Module   : ror_seq_32
// Brief    : Multi-cycle rotate-right unit, one bit per clock, done pulse.
// Revision : 1.0
// ============================================================================
module ror_seq_32 #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] rIn,
    input  logic [31:0]      rotB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rOut
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] C_ONE = AMT_W'(1);

    state_t             state_q, state_d;
    logic [AMT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   rout_q,  rout_d;

    // Only the low AMT_W bits of the amount matter (rotation is mod WIDTH).
    logic unused_rotb_hi;
    assign unused_rotb_hi = ^rotB[31:AMT_W];

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            rout_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rout_q  <= rout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rout_d  = rout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rout_d  = rIn;
                    count_d = rotB[AMT_W-1:0];
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A zero amount spends one SHIFT cycle without rotating, so
                // latency is max(n,1) edges for every n.
                if (count_q != '0) begin
                    rout_d  = {rout_q[0], rout_q[WIDTH-1:1]};
                    count_d = count_q - C_ONE;
                end
                if (count_q <= C_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done = (state_q == ST_DONE);
    assign rOut = rout_q;

endmodule
`default_nettype wire

// File: tb/tb_ror_seq_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_ror_seq_32
// Brief    : Directed and random self-checking bench for ror_seq_32.
// Revision : 1.0
// ============================================================================
module tb_ror_seq_32;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic [31:0] r_in;
    logic [31:0] rot_b;
    logic        busy;
    logic        done;
    logic [31:0] r_out;

    int n_checks;
    int n_errors;

    ror_seq_32 #(.WIDTH(32), .AMT_W(5)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .start (start),
        .rIn   (r_in),
        .rotB  (rot_b),
        .busy  (busy),
        .done  (done),
        .rOut  (r_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror_model(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = a;
        for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
        return r;
    endfunction

    // Issue one request in IDLE, wait for done, check result and latency,
    // then let DONE->IDLE happen so the next call has its IDLE gap.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input bit poke);
        int lat;
        int exp_lat;
        exp_lat = (b[4:0] == 5'd0) ? 1 : int'(b[4:0]);
        lat = 0;
        @(negedge clk);
        start = 1'b1;
        r_in  = a;
        rot_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
        chk({tag, "_done_at_accept"}, {31'd0, done}, 32'd0);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (poke && k == 3) begin
                start = 1'b1;
                r_in  = 32'hFFFF_FFFF;
                rot_b = 32'd2;
            end else if (poke) begin
                start = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, r_out, exp_res);
        @(posedge clk);
        #1;
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks = 0;
        n_errors = 0;
        clr_n = 1'b0;
        start = 1'b0;
        r_in  = 32'h0;
        rot_b = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rout", r_out, 32'h0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        clr_n = 1'b1;

        // Directed cases with hand-computed results.
        run_op("t1", 32'h0000_0001, 32'd1,  32'h8000_0000, 1'b0);
        run_op("t2", 32'h1234_5678, 32'd8,  32'h7812_3456, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("t2_hold", r_out, 32'h7812_3456);
        end
        run_op("t3a", 32'hDEAD_BEEF, 32'd0,  32'hDEAD_BEEF, 1'b0);
        run_op("t3b", 32'hDEAD_BEEF, 32'd32, 32'hDEAD_BEEF, 1'b0);
        run_op("t3c", 32'hDEAD_BEEF, 32'd33, 32'hEF56_DF77, 1'b0);
        run_op("t4",  32'h8000_0001, 32'd31, 32'h0000_0003, 1'b1);

        // Reset asserted at the 5th shift edge of a 16-bit rotate.
        @(negedge clk);
        start = 1'b1;
        r_in  = 32'hAAAA_5555;
        rot_b = 32'd16;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_pre_rout", r_out, 32'h5AAA_A555);
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        chk("t5_rst_rout", r_out, 32'h0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("t5_no_done", {31'd0, done}, 32'd0);
        end
        run_op("t5_fresh", 32'hAAAA_5555, 32'd16, 32'h5555_AAAA, 1'b0);

        // Random sweep against the bit-serial model.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op("rnd", ra, rb, ror_model(ra, int'(rb[4:0])), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
